// File: rtl/line_sum_printer.sv
// line_sum_printer: sums ASCII unsigned decimal numbers on each line and prints
// the sum in decimal (leading zeros suppressed), or E/O for malformed or
// overflowing lines. It sits between a UART receiver and a transmitter.
module line_sum_printer #(
  parameter int W      = 32,  // value and sum width in bits (>= 4)
  parameter int DIGITS = 10   // must satisfy 10**DIGITS > 2**W - 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       input_valid,
  input  logic [7:0] input_data,
  output logic       input_ready,
  input  logic       output_busy,
  output logic       output_en,
  output logic [7:0] output_data
);

  localparam int BW = 4 * DIGITS;          // BCD register width
  localparam int CW = $clog2(W + 1);       // conversion bit counter width
  localparam int DW = $clog2(DIGITS + 1);  // digit index width

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_O     = 8'h4F;

  typedef enum logic [1:0] {
    S_PARSE,
    S_CONVERT,
    S_SEND,
    S_TERM
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    cur_q, cur_d;
  logic [W-1:0]    sum_q, sum_d;         // doubles as the shift source during conversion
  logic            pending_q, pending_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic [BW-1:0]   bcd_q, bcd_d;         // most significant digit always in the top nibble
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   digit_idx_q, digit_idx_d;  // index of the digit in the top nibble
  logic            leading_q, leading_d; // still inside the leading-zero run

  // One double-dabble step: add 3 to every nibble >= 5, then shift in one bit.
  function automatic logic [BW-1:0] dabble_step(input logic [BW-1:0] bcd,
                                                input logic          in_bit);
    logic [BW-1:0] adj;
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BW-2:0], in_bit};
  endfunction

  logic          is_digit, is_sep, is_lf, is_cr;
  logic [3:0]    in_digit;
  logic [W+3:0]  cur_prod;
  logic [W:0]    sum_add;
  logic [3:0]    msd;
  logic          last_digit;
  logic          err_line;

  // Byte classification and the two parse-time arithmetic results.
  always_comb begin
    is_digit = (input_data >= 8'h30) && (input_data <= 8'h39);
    is_sep   = (input_data == CH_SPACE) || (input_data == CH_COMMA);
    is_lf    = (input_data == CH_LF);
    is_cr    = (input_data == CH_CR);
    in_digit = input_data[3:0];
    // cur * 10 + digit, wide enough that the overflow bits are visible
    cur_prod = ({4'b0000, cur_q} << 3) + ({4'b0000, cur_q} << 1)
             + {{W{1'b0}}, in_digit};
    sum_add  = {1'b0, sum_q} + {1'b0, cur_q};
  end

  assign msd         = bcd_q[BW-1 -: 4];
  assign last_digit  = (digit_idx_q == '0);
  assign err_line    = err_q || ovf_q;
  assign input_ready = (state_q == S_PARSE);

  // Output byte decoded purely from registered state.
  always_comb begin
    output_en   = 1'b0;
    output_data = 8'h00;
    case (state_q)
      S_SEND: begin
        if (err_line) begin
          output_en   = 1'b1;
          output_data = err_q ? CH_E : CH_O;
        end else if (!leading_q || (msd != 4'd0) || last_digit) begin
          output_en   = 1'b1;
          output_data = {4'h3, msd};
        end
      end
      S_TERM: begin
        output_en   = 1'b1;
        output_data = CH_LF;
      end
      default: ;
    endcase
  end

  // Next-state logic: parsing, conversion, digit sequencing and line reset.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cur_d       = cur_q;
    sum_d       = sum_q;
    pending_d   = pending_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    bcd_d       = bcd_q;
    bit_cnt_d   = bit_cnt_q;
    digit_idx_d = digit_idx_q;
    leading_d   = leading_q;

    case (state_q)
      S_PARSE: begin
        if (input_valid) begin
          if (is_digit) begin
            cur_d     = cur_prod[W-1:0];
            pending_d = 1'b1;
            if (cur_prod[W+3:W] != 4'd0) ovf_d = 1'b1;
          end else if (is_sep || is_lf) begin
            if (pending_q) begin
              sum_d = sum_add[W-1:0];
              if (sum_add[W]) ovf_d = 1'b1;
            end
            cur_d     = '0;
            pending_d = 1'b0;
            if (is_lf) begin
              bcd_d       = '0;
              bit_cnt_d   = '0;
              digit_idx_d = DW'(DIGITS - 1);
              leading_d   = 1'b1;
              // The fold above may itself overflow, so look at the new flags.
              state_d     = (err_d || ovf_d) ? S_SEND : S_CONVERT;
            end
          end else if (!is_cr) begin
            err_d = 1'b1;
          end
        end
      end

      S_CONVERT: begin
        bcd_d     = dabble_step(bcd_q, sum_q[W-1]);
        sum_d     = sum_q << 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q == CW'(W - 1)) state_d = S_SEND;
      end

      S_SEND: begin
        if (err_line) begin
          if (!output_busy) state_d = S_TERM;
        end else if (!output_en) begin
          // Leading zero: drop it silently, one cycle per digit.
          bcd_d       = bcd_q << 4;
          digit_idx_d = digit_idx_q - DW'(1);
        end else if (!output_busy) begin
          leading_d = 1'b0;
          if (last_digit) begin
            state_d = S_TERM;
          end else begin
            bcd_d       = bcd_q << 4;
            digit_idx_d = digit_idx_q - DW'(1);
          end
        end
      end

      S_TERM: begin
        if (!output_busy) begin
          cur_d     = '0;
          sum_d     = '0;
          pending_d = 1'b0;
          err_d     = 1'b0;
          ovf_d     = 1'b0;
          state_d   = S_PARSE;
        end
      end

      default: state_d = S_PARSE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (rst) begin
      state_q     <= S_PARSE;
      cur_q       <= '0;
      sum_q       <= '0;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      bcd_q       <= '0;
      bit_cnt_q   <= '0;
      digit_idx_q <= '0;
      leading_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      sum_q       <= sum_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      bcd_q       <= bcd_d;
      bit_cnt_q   <= bit_cnt_d;
      digit_idx_q <= digit_idx_d;
      leading_q   <= leading_d;
    end
  end

endmodule

// File: tb/tb_line_sum_printer.sv
// Testbench for line_sum_printer: directed lines from the test plan plus random
// lines, checked against a string-level reference model, on W=32 and W=8.
module tb_line_sum_printer;

  localparam logic [7:0] LF = 8'h0A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       busy;
  bit         sel;   // 0: W=32 instance, 1: W=8 instance

  logic       r32, e32, r8, e8;
  logic [7:0] d32, d8;

  line_sum_printer #(.W(32), .DIGITS(10)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .input_valid (valid && !sel),
    .input_data  (data),
    .input_ready (r32),
    .output_busy (sel ? 1'b0 : busy),
    .output_en   (e32),
    .output_data (d32)
  );

  line_sum_printer #(.W(8), .DIGITS(3)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .input_valid (valid && sel),
    .input_data  (data),
    .input_ready (r8),
    .output_busy (sel ? busy : 1'b0),
    .output_en   (e8),
    .output_data (d8)
  );

  logic       o_ready, o_en;
  logic [7:0] o_data;
  assign o_ready = sel ? r8 : r32;
  assign o_en    = sel ? e8 : e32;
  assign o_data  = sel ? d8 : d32;

  int n_pass  = 0;
  int n_total = 0;

  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == LF)         r = {r, "\\n"};
      else if (s[i] == 8'h0D) r = {r, "\\r"};
      else                    r = {r, s.substr(i, i)};
    end
    return r;
  endfunction

  task automatic check(string tag, string got, string exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", tag, vis(got), vis(exp));
  endtask

  // Reference model: the printed response for one line, from plain arithmetic.
  function automatic string model(string line, int w);
    longint unsigned lim = 64'd1 << w;
    longint unsigned cur = 0, sum = 0;
    bit pend = 0, err = 0, ovf = 0;
    for (int i = 0; i < line.len(); i++) begin
      byte c = line[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        cur = cur * 10 + longint'(c - 8'h30);
        if (cur >= lim) begin ovf = 1; cur = cur % lim; end
        pend = 1;
      end else if (c == 8'h20 || c == 8'h2C || c == LF) begin
        if (pend) begin
          sum = sum + cur;
          if (sum >= lim) begin ovf = 1; sum = sum % lim; end
        end
        cur = 0; pend = 0;
        if (c == LF) break;
      end else if (c != 8'h0D) begin
        err = 1;
      end
    end
    if (err) return "E\n";
    if (ovf) return "O\n";
    return $sformatf("%0d\n", sum);
  endfunction

  function automatic string rand_line(int w);
    string s = "";
    int n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) begin
      longint unsigned v;
      int kind = $urandom_range(0, 9);
      if (kind == 0)      v = longint'($urandom);
      else if (kind == 1) v = {$urandom, $urandom} % 64'd1000000000000;
      else                v = $urandom_range(0, (w == 8) ? 150 : 100000);
      s = {s, $sformatf("%0d", v)};
      if ($urandom_range(0, 11) == 0) s = {s, "x"};
      s = {s, ($urandom_range(0, 1) != 0) ? " " : ","};
      if ($urandom_range(0, 4) == 0) s = {s, " "};
    end
    if ($urandom_range(0, 7) == 0) s = {s, "\r"};
    return {s, "\n"};
  endfunction

  // Drive one line byte by byte; returns the cycle in which '\n' was consumed.
  task automatic send_line(string s, output int n_lf);
    n_lf = -1;
    for (int i = 0; i < s.len(); i++) begin
      int t = 0;
      valid = 1'b1;
      data  = s[i];
      while (!o_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("in_ready_wait", "timeout", "ready");
      if (s[i] == LF) n_lf = cyc;
      @(negedge clk);
    end
    valid = 1'b0;
    data  = 8'h00;
  endtask

  // Collect output bytes up to '\n' with optional random backpressure.
  task automatic collect(string tag, int busy_max, output string got, output int first_cyc);
    int       busy_left = 0;
    bit       held = 0, done = 0, bad_ready = 0;
    logic [7:0] held_data = 8'h00;
    got = "";
    first_cyc = -1;
    for (int k = 0; k < 600 && !done; k++) begin
      if (busy_max > 0 && busy_left > 0) begin
        busy = 1'b1; busy_left--;
      end else begin
        busy = 1'b0;
        if (busy_max > 0) busy_left = $urandom_range(0, busy_max);
      end
      if (held)
        check({"hold_stable ", tag}, $sformatf("%0b/%02h", o_en, o_data),
              $sformatf("1/%02h", held_data));
      held = 0;
      if (o_ready) bad_ready = 1;
      if (o_en) begin
        if (busy) begin
          held = 1; held_data = o_data;
        end else begin
          if (first_cyc < 0) first_cyc = cyc;
          got = {got, $sformatf("%c", o_data)};
          if (o_data == LF) done = 1;
        end
      end
      @(negedge clk);
    end
    busy = 1'b0;
    check({"ready_low ", tag}, bad_ready ? "1" : "0", "0");
    check({"ready_after ", tag}, o_ready ? "1" : "0", "1");
  endtask

  task automatic do_line(string s, string exp, int busy_max, int exp_lat);
    int    n_lf, first_cyc;
    string got;
    send_line(s, n_lf);
    collect(vis(s), busy_max, got, first_cyc);
    check({"line ", vis(s)}, got, exp);
    if (exp_lat >= 0)
      check({"latency ", vis(s)}, $sformatf("%0d", first_cyc - n_lf), $sformatf("%0d", exp_lat));
  endtask

  initial begin
    int    n_lf, seen, t;
    string s;

    rst = 1'b1; valid = 1'b0; data = 8'h00; busy = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hold_w32", $sformatf("%0b %02h %0b", e32, d32, r32), "0 00 1");
    check("rst_hold_w8",  $sformatf("%0b %02h %0b", e8, d8, r8),    "0 00 1");
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_w32", $sformatf("%0b %02h %0b", e32, d32, r32), "0 00 1");
    check("rst_after_w8",  $sformatf("%0b %02h %0b", e8, d8, r8),    "0 00 1");

    // W = 32 directed
    do_line("12 34,5\n", "51\n", 0, 32 + 1 + 8);
    do_line("\n", "0\n", 0, 32 + 1 + 9);
    do_line("4294967295\n", "4294967295\n", 0, 33);
    do_line("4294967296\n", "O\n", 0, 1);
    do_line("4294967295 1\n", "O\n", 0, 1);
    do_line("1x2\n", "E\n", 0, 1);
    do_line("3\n", "3\n", 0, -1);
    do_line("99999999999x\n", "E\n", 0, 1);
    do_line("3\n", "3\n", 0, -1);
    do_line("7\r\n", "7\n", 0, -1);
    do_line("3\n", "3\n", 0, -1);
    do_line(" ,, 8,,\n", "8\n", 0, -1);
    do_line("100 200\n", "300\n", 0, -1);

    // Backpressure
    for (int i = 0; i < 4; i++) do_line("123\n", "123\n", 5, -1);

    // W = 32 random
    for (int i = 0; i < 20; i++) begin
      s = rand_line(32);
      do_line(s, model(s, 32), (i % 3 == 0) ? 3 : 0, -1);
    end

    // W = 8 directed and random
    sel = 1'b1;
    @(negedge clk);
    do_line("200 55\n", "255\n", 0, 8 + 1);
    do_line("200 56\n", "O\n", 0, 1);
    do_line("256\n", "O\n", 0, 1);
    do_line("0\n", "0\n", 0, 8 + 1 + 2);
    for (int i = 0; i < 10; i++) begin
      s = rand_line(8);
      do_line(s, model(s, 8), (i % 2 == 0) ? 2 : 0, -1);
    end

    // Reset in the middle of sending "98765"; the transmitter is reset too,
    // so bytes presented while rst is high do not count.
    sel = 1'b0;
    @(negedge clk);
    send_line("98765\n", n_lf);
    t = 0;
    while (!o_en && t < 200) begin @(negedge clk); t++; end
    check("abort_first_byte", $sformatf("%c", o_data), "9");
    @(negedge clk);            // '9' transferred at the preceding edge
    rst = 1'b1;
    @(negedge clk);
    check("abort_en_in_rst", $sformatf("%0b", o_en), "0");
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      if (o_en) seen++;
      @(negedge clk);
    end
    check("abort_no_more_bytes", $sformatf("%0d", seen), "0");
    do_line("4\n", "4\n", 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/line_sum_printer.md
# line_sum_printer

Parametrised line-oriented decimal accumulator that sits between the UART receiver and transmitter, in the same position as the single-number echo block. It parses ASCII unsigned decimal numbers separated by spaces or commas and sums each line. On `\n` it converts the sum to decimal with a sequential double-dabble and transmits it with leading zeros suppressed, followed by `\n`. Malformed characters and arithmetic overflow are reported per line as `E\n` and `O\n`.

## Interface
- `W`, 32, value and sum width in bits (≥ 4).
- `DIGITS`, 10, decimal digits emitted at most; must satisfy 10^DIGITS > 2^W − 1 (for example W=8 → 3, W=16 → 5, W=32 → 10).
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `input_valid`  in  1  byte on `input_data` is valid this cycle.
- `input_data`  in  8  received byte.
- `input_ready`  out  1  block accepts bytes; a byte is consumed when `input_valid && input_ready`.
- `output_busy`  in  1  transmitter cannot take a byte this cycle.
- `output_en`  out  1  `output_data` holds a byte to send.
- `output_data`  out  8  byte to send.

## Operation
- States: PARSE, CONVERT, SEND, TERM. Reset enters PARSE and clears `cur`, `sum`, `pending`, `err`, `ovf`.
- PARSE (`input_ready`=1). For each consumed byte:
  - `'0'..'9'`: `cur` ← `cur`·10 + digit. Compute in W+4 bits. If the result is ≥ 2^W, set `ovf`. Set `pending`.
  - `' '` or `','`: if `pending`, `sum` ← `sum` + `cur`. Compute in W+1 bits; a carry sets `ovf`. Clear `cur` and `pending`.
  - `'\r'`: ignored.
  - `'\n'`: fold a pending `cur` into `sum` exactly as for a separator, in the same cycle. Then go to CONVERT, or straight to SEND if `err` or `ovf` is set.
  - Any other byte: set `err`. Keep parsing to end of line.
- CONVERT (`input_ready`=0). Double-dabble over `sum` into a 4·DIGITS BCD register. Takes exactly W cycles: one bit per cycle, with add-3 applied to every nibble ≥ 5 before the shift.
- SEND:
  - Error line: emit one byte, `'E'` if `err` is set, else `'O'`. `err` takes priority over `ovf`.
  - Otherwise emit BCD digits MSD first as `nibble + 0x30`.
  - Leading zero digits are skipped internally; each skip costs one cycle and emits no byte. The least significant digit is always sent, so a sum of 0 prints `"0"`.
- TERM: emit `'\n'`. When it is accepted, clear `cur`, `sum`, `pending`, `err`, `ovf` and return to PARSE.
- Bytes presented while `input_ready`=0 are not consumed. Upstream must hold them, or accept that they are lost.
- An empty line, or a line with only separators, prints `0\n`. Consecutive separators are harmless.

## Timing
- While `rst` is high, and in the first cycle after it is released: `output_en`=0, `output_data`=0x00, `input_ready`=1, state=PARSE.
- `output_en` and `output_data` are registered or decoded from registered state only. They never depend combinationally on `output_busy` or on input signals.
- A byte transfer occurs on each cycle where `output_en`=1 and `output_busy`=0. `output_data` is stable while `output_en`=1 and `output_busy`=1.
- After a transfer, the next byte may be presented on the following cycle, giving back-to-back bytes when the line is never busy.
- Latency, with `'\n'` consumed in cycle N:
  - Non-error line: CONVERT covers cycles N+1..N+W. Leading-zero skips take one cycle each. The first digit has `output_en` high at cycle N+W+1+z, where z is the number of skipped leading zeros.
  - Error line: `'E'` or `'O'` is presented at cycle N+1.
- `input_ready` returns high the cycle after the `'\n'` transfer in TERM.
- A `rst` asserted mid-line, mid-CONVERT or mid-SEND aborts immediately. No further output bytes are produced, and the next line parses from a clean state.
- Overflow of `cur` is sticky for the line even if later digits would have wrapped back into range.

## Test plan
- W=32: `"12 34,5\n"` → exactly `"51\n"`. The first digit appears W+1+8 cycles after `'\n'` is consumed, since 8 leading zeros of 10 digits are skipped.
- W=32: `"\n"` → `"0\n"`; `"4294967295\n"` → `"4294967295\n"`; `"4294967296\n"` → `"O\n"`; `"4294967295 1\n"` → `"O\n"`.
- W=32: `"1x2\n"` → `"E\n"`; `"99999999999x\n"` → `"E\n"` (err beats ovf); `"7\r\n"` → `"7\n"`. Each is followed by `"3\n"` → `"3\n"`, confirming flags were cleared.
- W=8, DIGITS=3: `"200 55\n"` → `"255\n"`; `"200 56\n"` → `"O\n"`; `"256\n"` → `"O\n"`.
- Backpressure: hold `output_busy` high for random 0–5 cycle spans while sending `"123\n"`. Required: `output_data` stays stable while busy, each byte transfers exactly once, and `input_ready` stays 0 until `'\n'` is accepted.
- Reset mid-SEND of `"98765\n"`, after the `'9'` transfer: no more bytes are output. The next input `"4\n"` → `"4\n"`.
